// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   INSTR_W / ADDR_W : instruction and byte-address widths
//   PC_STEP          : sequential PC increment (one 32-bit word)
//   fetch_state_e    : fetch FSM states (boot, run, halt)
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with a valid/ready handshake toward decode.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   flush_i         : drop the held instruction (payload is kept, valid cleared)
//   load_i          : capture instr_i / pc_i, compute pc+4, set valid
//   id_ready_i      : decode accepts the current contents this cycle
//   instr_i, pc_i   : word and its address from the fetch stage
//   valid_o         : register holds a valid instruction
//   instr_o, pc_o   : registered instruction and its PC
//   pc_plus4_o      : registered PC + 4 (wraps modulo 2^32)
module if_id_reg
  import fetch_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               load_i,
  input  logic               id_ready_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [ADDR_W-1:0]  pc_plus4_o
);

  logic               valid_d, valid_q;
  logic [INSTR_W-1:0] instr_d, instr_q;
  logic [ADDR_W-1:0]  pc_d, pc_q;
  logic [ADDR_W-1:0]  pc_plus4_d, pc_plus4_q;

  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d    = 1'b1;
      instr_d    = instr_i;
      pc_d       = pc_i;
      pc_plus4_d = pc_i + PC_STEP;
    end else if (id_ready_i) begin
      // Nothing new to load: whatever decode just consumed is gone.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the instruction memory and
// fills the IF/ID register; handles branch redirect (flush) and halt.
// Optional macro FETCH_FAULT_EN adds an alignment/range check on the PC and a
// sticky fetch_fault output.
// Ports:
//   clock, reset_n  : clock (rising edge), asynchronous active-low reset
//   direccion       : byte address to memory (the PC register)
//   salida          : memory word for direccion, same cycle
//   branch_taken    : redirect request; branch_target is the new PC
//   halt_req        : stop fetching (sticky until reset)
//   id_ready        : decode accepts IF/ID contents this cycle
//   id_valid, id_instr, id_pc, id_pc_plus4 : IF/ID register contents
//   halted          : FSM is in the halt state
//   fetch_fault     : sticky fault flag (FETCH_FAULT_EN only)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned       MEM_BYTES = 256
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic [ADDR_W-1:0]  direccion,
  input  logic [INSTR_W-1:0] salida,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               halt_req,
  input  logic               id_ready,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [ADDR_W-1:0]  id_pc_plus4,
  output logic               halted
`ifdef FETCH_FAULT_EN
  ,
  output logic               fetch_fault
`endif
);

  if ((MEM_BYTES < 4) || (MEM_BYTES % 4 != 0)) begin : g_mem_bytes_check
    $error("fetch_unit: MEM_BYTES must be a non-zero multiple of 4");
  end

  fetch_state_e      state_d, state_q;
  logic [ADDR_W-1:0] pc_d, pc_q;
  logic              load;
  logic              flush;
  logic              advance;

`ifdef FETCH_FAULT_EN
  localparam logic [ADDR_W-1:0] FaultLimit = ADDR_W'(MEM_BYTES) - PC_STEP;

  logic fault_d, fault_q;
  logic pc_bad;

  assign pc_bad = (pc_q[1:0] != 2'b00) || (pc_q > FaultLimit);
`endif

  // Free slot, or decode is draining the occupied one this cycle.
  assign advance = !id_valid || id_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    flush   = 1'b0;
`ifdef FETCH_FAULT_EN
    fault_d = fault_q;
`endif
    unique case (state_q)
      StBoot: begin
        state_d = StRun;
      end
      StRun: begin
        if (branch_taken) begin
          pc_d  = branch_target;
          flush = 1'b1;
        end else if (halt_req) begin
          // No load: the register drains on its own if decode is ready,
          // otherwise the held instruction waits for acceptance.
          state_d = StHalt;
`ifdef FETCH_FAULT_EN
        end else if (pc_bad) begin
          flush   = 1'b1;
          fault_d = 1'b1;
          state_d = StHalt;
`endif
        end else if (advance) begin
          load = 1'b1;
          pc_d = pc_q + PC_STEP;
        end
      end
      StHalt: begin
        // Frozen; the IF/ID register still drains when decode accepts.
      end
      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef FETCH_FAULT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fetch_fault = fault_q;
`endif

  if_id_reg u_if_id_reg (
    .clk_i      (clock),
    .rst_ni     (reset_n),
    .flush_i    (flush),
    .load_i     (load),
    .id_ready_i (id_ready),
    .instr_i    (salida),
    .pc_i       (pc_q),
    .valid_o    (id_valid),
    .instr_o    (id_instr),
    .pc_o       (id_pc),
    .pc_plus4_o (id_pc_plus4)
  );

  assign direccion = pc_q;
  assign halted    = (state_q == StHalt);

endmodule
